// File: rtl/commit_arbiter.sv
// Round-robin writeback arbiter: picks one execution-unit result per cycle and registers it toward the register file.
// Optional contention counter (perf_conflicts) is built only when COMMIT_ARB_PERF_EN is defined.

package core_config_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
endpackage

module commit_arbiter
  import core_config_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]      req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush,
  output logic                         wb_write,
  output logic [REG_ADDR_W-1:0]        wb_address,
  output logic [XLEN-1:0]              wb_data
`ifdef COMMIT_ARB_PERF_EN
  ,
  output logic [31:0]                  perf_conflicts
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand;
  logic [NUM_REQ-1:0]    grant_oh;
  logic                  found;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  // Search starts one past the last winner and wraps, so a waiting requester is served within NUM_REQ-1 cycles.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

  assign req_ready = (rst_n && !flush) ? grant_oh : '0;
  assign xfer      = |req_ready;
  assign sel_rd    = req_rd[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_data  = req_data[int'(grant_idx)*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      wb_write   <= 1'b0;
      wb_address <= '0;
      wb_data    <= '0;
    end else if (xfer) begin
      last_grant <= grant_idx;
      // x0 writes still consume the grant but never reach the register file.
      wb_write   <= (sel_rd != '0);
      wb_address <= sel_rd;
      wb_data    <= sel_data;
    end else begin
      wb_write   <= 1'b0;
    end
  end

`ifdef COMMIT_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflicts <= '0;
    end else if (!flush && ($countones(req_valid) >= 2)) begin
      perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed bench for commit_arbiter: grant order, writeback timing, x0, flush and reset behaviour.
module tb_commit_arbiter;
  localparam int NUM_REQ = 4;
  localparam int XL = 32;
  localparam int RW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*RW-1:0] req_rd = '0;
  logic [NUM_REQ*XL-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 flush = 1'b0;
  logic                 wb_write;
  logic [RW-1:0]        wb_address;
  logic [XL-1:0]        wb_data;
`ifdef COMMIT_ARB_PERF_EN
  logic [31:0]          perf_conflicts;
`endif

  int compared = 0;
  int mismatched = 0;

  commit_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_rd(req_rd),
    .req_data(req_data),
    .req_ready(req_ready),
    .flush(flush),
    .wb_write(wb_write),
    .wb_address(wb_address),
    .wb_data(wb_data)
`ifdef COMMIT_ARB_PERF_EN
    ,
    .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [RW-1:0] rd, input logic [XL-1:0] d);
    req_rd[i*RW +: RW]   = rd;
    req_data[i*XL +: XL] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    flush = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wb_write", 32'(wb_write), 32'h0);
    chk("rst_wb_address", 32'(wb_address), 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    do_reset();

    // Single request
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 4'b0001;
    #1 chk("single_ready", 32'(req_ready), 32'b0001);
    step();
    chk("single_wb_write", 32'(wb_write), 32'h1);
    chk("single_wb_address", 32'(wb_address), 32'd5);
    chk("single_wb_data", wb_data, 32'hDEADBEEF);
    req_valid = 4'b0000;
    #1 chk("idle_ready", 32'(req_ready), 32'h0);
    step();
    chk("idle_wb_write", 32'(wb_write), 32'h0);
    chk("idle_wb_address_hold", 32'(wb_address), 32'd5);
    chk("idle_wb_data_hold", wb_data, 32'hDEADBEEF);

    // Round-robin with all four valid, starting fresh from reset
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, RW'(i + 1), 32'hA000_0000 + 32'(i));
    req_valid = 4'b1111;
    #1 chk("rr0_ready", 32'(req_ready), 32'b0001);
    step();
    chk("rr0_wb_address", 32'(wb_address), 32'd1);
    chk("rr0_wb_data", wb_data, 32'hA000_0000);
    chk("rr1_ready", 32'(req_ready), 32'b0010);
    step();
    chk("rr1_wb_address", 32'(wb_address), 32'd2);
    chk("rr2_ready", 32'(req_ready), 32'b0100);
    step();
    chk("rr2_wb_address", 32'(wb_address), 32'd3);
    chk("rr3_ready", 32'(req_ready), 32'b1000);
    step();
    chk("rr3_wb_address", 32'(wb_address), 32'd4);
    chk("rr3_wb_data", wb_data, 32'hA000_0003);
    chk("rr4_ready", 32'(req_ready), 32'b0001);
    step();
    chk("rr4_wb_address", 32'(wb_address), 32'd1);
    chk("rr4_wb_write", 32'(wb_write), 32'h1);
`ifdef COMMIT_ARB_PERF_EN
    chk("rr_perf", perf_conflicts, 32'd5);
`endif
    req_valid = 4'b0000;
    step();

    // Bring last_grant to 2, then wrap to 0 and 1 while 2/3 idle
    req_valid = 4'b0100;
    #1 chk("pre_wrap_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0011;
    #1 chk("wrap0_ready", 32'(req_ready), 32'b0001);
    step();
    chk("wrap1_ready", 32'(req_ready), 32'b0010);
    step();

    // x0 destination: grant consumed, no write
    set_req(1, 5'd0, 32'h1111_1111);
    req_valid = 4'b0010;
    #1 chk("x0_ready", 32'(req_ready), 32'b0010);
    step();
    chk("x0_wb_write", 32'(wb_write), 32'h0);
    req_valid = 4'b0110;
    #1 chk("after_x0_ready", 32'(req_ready), 32'b0100);
    step();
    chk("after_x0_wb_write", 32'(wb_write), 32'h1);
    chk("after_x0_wb_address", 32'(wb_address), 32'd3);

    // Flush blocks the grant for one cycle
    req_valid = 4'b0100;
    flush = 1'b1;
    #1 chk("flush_ready", 32'(req_ready), 32'b0000);
    step();
    chk("flush_wb_write", 32'(wb_write), 32'h0);
    flush = 1'b0;
    #1 chk("post_flush_ready", 32'(req_ready), 32'b0100);
    step();
    chk("post_flush_wb_write", 32'(wb_write), 32'h1);
    chk("post_flush_wb_address", 32'(wb_address), 32'd3);

    // Reset while requester 3 holds the grant
    req_valid = 4'b1000;
    #1 chk("pre_rst_ready", 32'(req_ready), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'b0000);
    chk("mid_rst_wb_write", 32'(wb_write), 32'h0);
    step();
    req_valid = 4'b0000;
    rst_n = 1'b1;
    step();
    chk("post_rst_wb_write", 32'(wb_write), 32'h0);
    chk("post_rst_wb_address", 32'(wb_address), 32'h0);
    set_req(0, 5'd7, 32'h0BAD_F00D);
    req_valid = 4'b1001;
    #1 chk("post_rst_ready", 32'(req_ready), 32'b0001);
    step();
    chk("post_rst_grant_wb_address", 32'(wb_address), 32'd7);
    chk("post_rst_grant_wb_data", wb_data, 32'h0BAD_F00D);
    req_valid = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/commit_arbiter.md
COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of execution-unit result requesters (2..8).
REQ-002 SHALL use XLEN (32) and REG_ADDR_W (5) from core_config_pkg for data and register-address widths.
REQ-003 SHALL have clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have req_valid  input  NUM_REQ  per-requester result valid.
REQ-006 SHALL have req_rd  input  NUM_REQ*REG_ADDR_W  per-requester destination register; slice i = [i*REG_ADDR_W +: REG_ADDR_W].
REQ-007 SHALL have req_data  input  NUM_REQ*XLEN  per-requester result data; slice i = [i*XLEN +: XLEN].
REQ-008 SHALL have req_ready  output  NUM_REQ  one-hot grant/accept, combinational.
REQ-009 SHALL have flush  input  1  synchronous pipeline flush.
REQ-010 SHALL have wb_write  output  1  register-file write enable, registered.
REQ-011 SHALL have wb_address  output  REG_ADDR_W  register-file and scoreboard write/release address, registered.
REQ-012 SHALL have wb_data  output  XLEN  register-file write data, registered.
REQ-013 SHALL have perf_conflicts  output  32  contention counter; present only with COMMIT_ARB_PERF_EN.

Function
REQ-014 SHALL grant at most one requester per cycle; req_ready SHALL be one-hot or zero.
REQ-015 SHALL assert req_ready[i] only when req_valid[i] is high; a transfer completes when req_valid[i] and req_ready[i] are both high.
REQ-016 SHALL arbitrate round-robin: priority starts at index (last_grant+1) mod NUM_REQ and proceeds upward with wrap-around.
REQ-017 SHALL update last_grant to the granted index only on a completed transfer; with no transfer it SHALL hold.
REQ-018 SHALL register the accepted transfer so that wb_write/wb_address/wb_data appear exactly 1 cycle after acceptance (latency 1, throughput 1 per cycle).
REQ-019 SHALL drive wb_write=0 in any cycle following a cycle with no transfer; wb_address/wb_data SHALL hold their last values.
REQ-020 SHALL accept a transfer with rd=0 (consumes grant, advances last_grant) but SHALL drive wb_write=0 for it.
REQ-021 SHALL, when flush=1, deassert all req_ready in that cycle and drive wb_write=0 in the next cycle; last_grant SHALL hold.
REQ-022 SHALL let a requester holding req_valid with no grant keep its rd/data stable; the arbiter SHALL not require a minimum wait beyond NUM_REQ-1 cycles (starvation-free).

Reset
REQ-023 SHALL, on rst_n low, asynchronously set wb_write=0, wb_address=0, wb_data=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), perf_conflicts=0.
REQ-024 SHALL hold req_ready=0 while rst_n is low; a transfer in flight at reset assertion SHALL be discarded.

Configuration
REQ-025 SHALL, with macro COMMIT_ARB_PERF_EN defined, include perf_conflicts, incremented by 1 each cycle with two or more req_valid bits high and flush=0, wrapping from 0xFFFFFFFF to 0.
REQ-026 SHALL, without COMMIT_ARB_PERF_EN, omit the perf_conflicts port and counter entirely; all other behaviour SHALL be identical.

Verification
REQ-027 Single request: after reset, req_valid=0001, rd0=5, data0=0xDEADBEEF -> req_ready=0001 same cycle; next cycle wb_write=1, wb_address=5, wb_data=0xDEADBEEF.
REQ-028 Round-robin: req_valid=1111 held 5 cycles, distinct rd 1..4 -> grants 0,1,2,3,0; wb_address 1,2,3,4,1 each one cycle later; perf_conflicts=5 (with macro).
REQ-029 Wrap and skip: last_grant=2, req_valid=0011 -> grant index 0, then index 1; index 2/3 never granted.
REQ-030 x0 write: req_valid=0010, rd1=0 -> req_ready=0010; next cycle wb_write=0; following request from index 2 wins over index 1 if both valid.
REQ-031 Flush: req_valid=0100 with flush=1 -> req_ready=0000, next wb_write=0; flush=0 next cycle -> grant 0100, wb_write=1 one cycle later.
REQ-032 Reset mid-operation: rst_n low while req_ready=1000 -> wb_write=0 immediately, no writeback after release; first grant after release goes to index 0 when req_valid=1001.
